// File: rtl/rcu_pkg.sv
// rcu_pkg: shared rename/issue types and constants for the physical register file.
package rcu_pkg;
  localparam int PRF_AW = 7;
  localparam int PRF_XLEN = 64;
  typedef logic [PRF_AW-1:0] prf_addr_t;
  typedef logic [PRF_XLEN-1:0] xlen_data_t;
  localparam prf_addr_t PRF_ZERO_ADDR = '0;
  function automatic logic prf_live(input prf_addr_t a, input int size);
    return a != PRF_ZERO_ADDR && int'(a) < size;
  endfunction
  function automatic logic prf_in_range(input prf_addr_t a, input int size);
    return int'(a) < size;
  endfunction
endpackage

// File: rtl/prf_wr_arbiter.sv
// prf_wr_arbiter: picks the highest-index valid writeback that targets one address.
module prf_wr_arbiter
  import rcu_pkg::*;
#(
  parameter int NUM_WR = 7
) (
  input  prf_addr_t                 i_addr,
  input  logic [NUM_WR-1:0]         i_wr_valid,
  input  logic [NUM_WR*PRF_AW-1:0]  i_wr_addr,
  input  logic [NUM_WR*PRF_XLEN-1:0] i_wr_data,
  output logic                      o_hit,
  output xlen_data_t                o_data
);
  always_comb begin
    o_hit = 1'b0;
    o_data = '0;
    for (int i = 0; i < NUM_WR; i++)
      if (i_wr_valid[i] && i_wr_addr[i*PRF_AW +: PRF_AW] == i_addr) begin
        o_hit = 1'b1;
        o_data = i_wr_data[i*PRF_XLEN +: PRF_XLEN];
      end
  end
endmodule

// File: rtl/physical_regfile_scb.sv
// physical_regfile_scb: physical register file with ready scoreboard, write bypass and conflict flag.
module physical_regfile_scb
  import rcu_pkg::*;
#(
  parameter int REG_SIZE = 128,
  parameter int REG_SIZE_WIDTH = PRF_AW,
  parameter int XLEN = PRF_XLEN,
  parameter int NUM_RD = 6,
  parameter int NUM_WR = 7,
  parameter int NUM_ALLOC = 2,
  parameter int BYPASS = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_RD*REG_SIZE_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]              rd_data_o,
  output logic [NUM_RD-1:0]                   rd_ready_o,
  input  logic [NUM_WR-1:0]                   wr_valid_i,
  input  logic [NUM_WR*REG_SIZE_WIDTH-1:0]    wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]              wr_data_i,
  input  logic [NUM_ALLOC-1:0]                alloc_valid_i,
  input  logic [NUM_ALLOC*REG_SIZE_WIDTH-1:0] alloc_addr_i,
  input  logic                                flush_i,
  output logic                                wr_conflict_o
);
  localparam int AW = REG_SIZE_WIDTH;
  xlen_data_t            r_data [REG_SIZE];
  logic [REG_SIZE-1:0]   r_ready;
  logic                  r_conflict;
  logic [REG_SIZE-1:0]   w_ready_nxt;
  logic                  w_conflict;
  assign wr_conflict_o = r_conflict;
  // Priority low to high so later assignments win: write sets, alloc clears, flush sets.
  always_comb begin
    w_ready_nxt = r_ready;
    for (int r = 1; r < REG_SIZE; r++) begin
      for (int i = 0; i < NUM_WR; i++)
        if (wr_valid_i[i] && wr_addr_i[i*AW +: AW] == AW'(r)) w_ready_nxt[r] = 1'b1;
      for (int a = 0; a < NUM_ALLOC; a++)
        if (alloc_valid_i[a] && alloc_addr_i[a*AW +: AW] == AW'(r)) w_ready_nxt[r] = 1'b0;
    end
    w_ready_nxt[0] = 1'b1;
    if (flush_i) w_ready_nxt = '1;
  end
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_valid_i[i] && wr_valid_i[j] && wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW]
            && prf_live(wr_addr_i[i*AW +: AW], REG_SIZE))
          w_conflict = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_SIZE; r++) r_data[r] <= '0;
      r_ready <= '1;
      r_conflict <= 1'b0;
    end else begin
      for (int r = 1; r < REG_SIZE; r++)
        for (int i = 0; i < NUM_WR; i++)
          if (wr_valid_i[i] && wr_addr_i[i*AW +: AW] == AW'(r)) r_data[r] <= wr_data_i[i*XLEN +: XLEN];
      r_ready <= w_ready_nxt;
      r_conflict <= r_conflict | w_conflict;
      for (int i = 0; i < NUM_WR; i++)
        assert (!wr_valid_i[i] || prf_in_range(wr_addr_i[i*AW +: AW], REG_SIZE));
      for (int a = 0; a < NUM_ALLOC; a++)
        assert (!alloc_valid_i[a] || prf_in_range(alloc_addr_i[a*AW +: AW], REG_SIZE));
      for (int k = 0; k < NUM_RD; k++)
        assert (prf_in_range(rd_addr_i[k*AW +: AW], REG_SIZE));
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    prf_addr_t  w_addr;
    logic       w_live;
    logic       w_hit;
    xlen_data_t w_byp;
    assign w_addr = rd_addr_i[k*AW +: AW];
    assign w_live = prf_live(w_addr, REG_SIZE);
    prf_wr_arbiter #(.NUM_WR(NUM_WR)) u_arb (
      .i_addr(w_addr), .i_wr_valid(wr_valid_i), .i_wr_addr(wr_addr_i),
      .i_wr_data(wr_data_i), .o_hit(w_hit), .o_data(w_byp)
    );
    assign rd_data_o[k*XLEN +: XLEN] = !w_live ? '0 : (BYPASS != 0 && w_hit) ? w_byp : r_data[w_addr];
    assign rd_ready_o[k] = !w_live || (BYPASS != 0 && w_hit) || r_ready[w_addr];
  end
endmodule

// File: tb/tb_physical_regfile_scb.sv
// tb_physical_regfile_scb: directed checks of the register file with and without write bypass.
module tb_physical_regfile_scb;
  localparam int AW = 7, XL = 64, NR = 6, NW = 7, NA = 2;
  logic clk = 1'b0;
  logic rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*XL-1:0] d1, d0;
  logic [NR-1:0]    rdy1, rdy0;
  logic [NW-1:0]    wr_valid;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*XL-1:0] wr_data;
  logic [NA-1:0]    alloc_valid;
  logic [NA*AW-1:0] alloc_addr;
  logic             flush;
  logic             conf1, conf0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  physical_regfile_scb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(d1), .rd_ready_o(rdy1),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr), .flush_i(flush), .wr_conflict_o(conf1)
  );
  physical_regfile_scb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(d0), .rd_ready_o(rdy0),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr), .flush_i(flush), .wr_conflict_o(conf0)
  );
  function automatic logic [XL-1:0] dat(input logic [NR*XL-1:0] v, input int k);
    return v[k*XL +: XL];
  endfunction
  task automatic clear();
    rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
    alloc_valid = '0; alloc_addr = '0; flush = 1'b0;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask
  task automatic set_wr(input int i, input int a, input logic [XL-1:0] d);
    wr_valid[i] = 1'b1; wr_addr[i*AW +: AW] = AW'(a); wr_data[i*XL +: XL] = d;
  endtask
  task automatic set_alloc(input int i, input int a);
    alloc_valid[i] = 1'b1; alloc_addr[i*AW +: AW] = AW'(a);
  endtask
  task automatic do_reset();
    clear(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NR; k++) set_rd(k, 5);
    #1;
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (dat(d1, k) !== '0 || rdy1[k] !== 1'b1) begin
        failures++; $display("FAIL reset_read port%0d data=%h ready=%b exp data=0 ready=1", k, dat(d1, k), rdy1[k]);
      end
    end
    checks++;
    if (conf1 !== 1'b0 || conf0 !== 1'b0) begin
      failures++; $display("FAIL reset_conflict got=%b/%b exp=0", conf1, conf0);
    end
  endtask

  task automatic test_write();
    clear(); set_wr(0, 5, 64'hDEAD); step();
    clear(); for (int k = 0; k < NR; k++) set_rd(k, 5); #1;
    checks++;
    if (dat(d0, 0) !== 64'hDEAD || rdy0[0] !== 1'b1) begin
      failures++; $display("FAIL write_read data=%h ready=%b exp=dead/1", dat(d0, 0), rdy0[0]);
    end
    checks++;
    if (dat(d1, 5) !== 64'hDEAD) begin
      failures++; $display("FAIL write_read_p5 data=%h exp=dead", dat(d1, 5));
    end
  endtask

  task automatic test_bypass();
    clear(); set_wr(2, 9, 64'h1234); set_rd(0, 9); #1;
    checks++;
    if (dat(d1, 0) !== 64'h1234 || rdy1[0] !== 1'b1) begin
      failures++; $display("FAIL bypass_on data=%h ready=%b exp=1234/1", dat(d1, 0), rdy1[0]);
    end
    checks++;
    if (dat(d0, 0) !== 64'h0 || rdy0[0] !== 1'b1) begin
      failures++; $display("FAIL bypass_off data=%h ready=%b exp=0/1", dat(d0, 0), rdy0[0]);
    end
    step(); clear(); set_rd(0, 9); #1;
    checks++;
    if (dat(d0, 0) !== 64'h1234) begin
      failures++; $display("FAIL bypass_off_next data=%h exp=1234", dat(d0, 0));
    end
  endtask

  task automatic test_scoreboard();
    clear(); set_alloc(0, 12); step();
    clear(); set_rd(0, 12); #1;
    checks++;
    if (rdy1[0] !== 1'b0 || rdy0[0] !== 1'b0) begin
      failures++; $display("FAIL alloc_clears_ready got=%b/%b exp=0", rdy1[0], rdy0[0]);
    end
    set_wr(3, 12, 64'h55); #1;
    checks++;
    if (rdy1[0] !== 1'b1 || dat(d1, 0) !== 64'h55 || rdy0[0] !== 1'b0) begin
      failures++; $display("FAIL wb_same_cycle byp=%h/%b nb_ready=%b exp=55/1 0", dat(d1, 0), rdy1[0], rdy0[0]);
    end
    step(); clear(); set_rd(0, 12); #1;
    checks++;
    if (dat(d0, 0) !== 64'h55 || rdy0[0] !== 1'b1) begin
      failures++; $display("FAIL wb_sets_ready data=%h ready=%b exp=55/1", dat(d0, 0), rdy0[0]);
    end
    set_alloc(1, 12); set_wr(4, 12, 64'h66); step();
    clear(); set_rd(0, 12); #1;
    checks++;
    if (dat(d0, 0) !== 64'h66 || rdy0[0] !== 1'b0 || dat(d1, 0) !== 64'h66 || rdy1[0] !== 1'b0) begin
      failures++; $display("FAIL alloc_and_wb data=%h ready=%b exp=66/0", dat(d0, 0), rdy0[0]);
    end
  endtask

  task automatic test_conflict();
    clear(); set_wr(1, 20, 64'hAA); set_wr(6, 20, 64'hBB); set_rd(0, 20); #1;
    checks++;
    if (dat(d1, 0) !== 64'hBB || conf1 !== 1'b0) begin
      failures++; $display("FAIL conflict_bypass data=%h flag=%b exp=bb/0", dat(d1, 0), conf1);
    end
    step(); clear(); set_rd(0, 20); #1;
    checks++;
    if (dat(d0, 0) !== 64'hBB || conf0 !== 1'b1 || conf1 !== 1'b1) begin
      failures++; $display("FAIL conflict_write data=%h flag=%b/%b exp=bb/1", dat(d0, 0), conf0, conf1);
    end
    step(); step(); step();
    checks++;
    if (conf1 !== 1'b1) begin
      failures++; $display("FAIL conflict_sticky flag=%b exp=1", conf1);
    end
    do_reset(); #1;
    checks++;
    if (conf1 !== 1'b0) begin
      failures++; $display("FAIL conflict_rst_clear flag=%b exp=0", conf1);
    end
    clear(); set_wr(1, 0, 64'hAA); set_wr(6, 0, 64'hBB); set_rd(0, 0); #1;
    checks++;
    if (dat(d1, 0) !== 64'h0 || rdy1[0] !== 1'b1) begin
      failures++; $display("FAIL p0_bypass data=%h ready=%b exp=0/1", dat(d1, 0), rdy1[0]);
    end
    step(); clear(); set_rd(0, 0); #1;
    checks++;
    if (conf1 !== 1'b0 || conf0 !== 1'b0 || dat(d0, 0) !== 64'h0) begin
      failures++; $display("FAIL p0_conflict flag=%b data=%h exp=0/0", conf1, dat(d0, 0));
    end
  endtask

  task automatic test_flush();
    clear(); set_alloc(0, 30); set_alloc(1, 31); step();
    clear(); set_rd(0, 30); set_rd(1, 31); set_rd(2, 40); #1;
    checks++;
    if (rdy0[1:0] !== 2'b00) begin
      failures++; $display("FAIL flush_pre ready=%b exp=00", rdy0[1:0]);
    end
    flush = 1'b1; set_alloc(0, 40); step();
    clear(); set_rd(0, 30); set_rd(1, 31); set_rd(2, 40); #1;
    checks++;
    if (rdy0[2:0] !== 3'b111 || rdy1[2:0] !== 3'b111) begin
      failures++; $display("FAIL flush_ready ready=%b exp=111", rdy0[2:0]);
    end
  endtask

  task automatic test_reset_write();
    clear(); set_wr(1, 21, 64'h11); set_wr(2, 21, 64'h22); set_alloc(0, 50); step();
    clear(); set_rd(0, 50); #1;
    checks++;
    if (conf0 !== 1'b1 || rdy0[0] !== 1'b0) begin
      failures++; $display("FAIL prerst_state flag=%b ready=%b exp=1/0", conf0, rdy0[0]);
    end
    clear(); rst = 1'b1; set_wr(0, 7, 64'h77); set_alloc(1, 50); step();
    rst = 1'b0; clear(); set_rd(0, 7); set_rd(1, 50); set_rd(2, 21); set_rd(3, 9); #1;
    checks++;
    if (dat(d0, 0) !== 64'h0 || dat(d0, 2) !== 64'h0 || dat(d0, 3) !== 64'h0) begin
      failures++; $display("FAIL rst_write data=%h/%h/%h exp=0", dat(d0, 0), dat(d0, 2), dat(d0, 3));
    end
    checks++;
    if (rdy0[3:0] !== 4'hF || conf0 !== 1'b0 || conf1 !== 1'b0) begin
      failures++; $display("FAIL rst_ready_flag ready=%b flag=%b exp=1111/0", rdy0[3:0], conf0);
    end
  endtask

  initial begin
    clear();
    rst = 1'b1;
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_conflict();
    test_flush();
    test_reset_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
